// File: rtl/bus_responder.sv
// bus_responder
//   Memory-side responder for the 6502 core's address/data bus. Serves an
//   on-chip RAM, the fixed RESET/IRQ vectors, and a 16-bit down-counting
//   timer that can raise a level interrupt.
//
// Ports
//   i_clk   clock, all state changes on the rising edge
//   i_rst   asynchronous active-high reset
//   i_addr  16-bit bus address from the core
//   i_data  8-bit write data from the core
//   i_we    1 = write cycle, 0 = read cycle
//   o_data  registered read data (1-cycle latency, read-first on writes)
//   o_irq   registered level interrupt request, active-high
module bus_responder #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] TMR_BASE  = 16'hD000,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_we,
  output logic [7:0]  o_data,
  output logic        o_irq
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [7:0] mem [0:RAM_DEPTH-1];

  // Timer state
  logic [7:0]  rld_lo, rld_hi;
  logic        en, irqen, auto_rld, expd;
  logic [15:0] cnt;

  // Next-state values
  logic [7:0]  rld_lo_n, rld_hi_n;
  logic        en_n, irqen_n, auto_n, exp_n;
  logic [15:0] cnt_n;

  logic       ram_sel, tmr_sel, vec_sel;
  logic [2:0] off;
  logic [7:0] rd_data;

  assign ram_sel = (32'(i_addr) < 32'(RAM_DEPTH));
  assign tmr_sel = (i_addr[15:3] == TMR_BASE[15:3]);
  assign vec_sel = (i_addr[15:2] == 14'h3FFF);
  assign off     = i_addr[2:0];

  // Read mux, evaluated with pre-edge state so writes return old contents
  always_comb begin
    rd_data = 8'hFF;
    if (ram_sel) begin
      rd_data = mem[i_addr[RAM_AW-1:0]];
    end else if (tmr_sel) begin
      case (off)
        3'd0:    rd_data = rld_lo;
        3'd1:    rd_data = rld_hi;
        3'd2:    rd_data = {5'b0, auto_rld, irqen, en};
        3'd3:    rd_data = {7'b0, expd};
        3'd4:    rd_data = cnt[7:0];
        3'd5:    rd_data = cnt[15:8];
        default: rd_data = 8'hFF;
      endcase
    end else if (vec_sel) begin
      case (i_addr[1:0])
        2'd0:    rd_data = RESET_VEC[7:0];
        2'd1:    rd_data = RESET_VEC[15:8];
        2'd2:    rd_data = IRQ_VEC[7:0];
        default: rd_data = IRQ_VEC[15:8];
      endcase
    end
  end

  // Timer next state. A CTRL write that sets EN loads the counter and
  // suppresses that cycle's decrement/expiry; a CTRL write with EN=0 just
  // stops it. Expiry is applied after the STAT clear so it wins a tie.
  always_comb begin
    rld_lo_n = rld_lo;
    rld_hi_n = rld_hi;
    en_n     = en;
    irqen_n  = irqen;
    auto_n   = auto_rld;
    exp_n    = expd;
    cnt_n    = cnt;

    if (i_we && tmr_sel && !ram_sel) begin
      case (off)
        3'd0: rld_lo_n = i_data;
        3'd1: rld_hi_n = i_data;
        3'd2: begin
          en_n    = i_data[0];
          irqen_n = i_data[1];
          auto_n  = i_data[2];
        end
        3'd3: if (i_data[0]) exp_n = 1'b0;
        default: ;
      endcase
    end

    if (i_we && tmr_sel && !ram_sel && off == 3'd2) begin
      if (i_data[0]) cnt_n = {rld_hi, rld_lo};
    end else if (en && cnt != 16'd0) begin
      cnt_n = cnt - 16'd1;
    end else if (en) begin
      exp_n = 1'b1;
      if (auto_rld) cnt_n = {rld_hi, rld_lo};
      else          en_n  = 1'b0;
    end
  end

  // RAM array: no reset, read-first behaviour comes from rd_data above
  always_ff @(posedge i_clk) begin
    if (i_we && ram_sel) mem[i_addr[RAM_AW-1:0]] <= i_data;
  end

  // Registered state and outputs; o_irq follows next-state flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data   <= 8'h00;
      o_irq    <= 1'b0;
      rld_lo   <= 8'h00;
      rld_hi   <= 8'h00;
      en       <= 1'b0;
      irqen    <= 1'b0;
      auto_rld <= 1'b0;
      expd     <= 1'b0;
      cnt      <= 16'h0000;
    end else begin
      o_data   <= rd_data;
      o_irq    <= exp_n & irqen_n;
      rld_lo   <= rld_lo_n;
      rld_hi   <= rld_hi_n;
      en       <= en_n;
      irqen    <= irqen_n;
      auto_rld <= auto_n;
      expd     <= exp_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder
//   Directed bench for bus_responder: each bus cycle is driven, one clock
//   edge is taken, and o_data/o_irq are sampled 1 time unit after the edge
//   against hand-computed values.
module tb_bus_responder;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_addr;
  logic [7:0]  i_data;
  logic        i_we;
  logic [7:0]  o_data;
  logic        o_irq;

  int checks = 0;
  int errors = 0;

  bus_responder dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (i_addr),
    .i_data (i_data),
    .i_we   (i_we),
    .o_data (o_data),
    .o_irq  (o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One bus cycle: drive, take the edge, settle just past it
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input logic we);
    i_addr = addr;
    i_data = data;
    i_we   = we;
    @(posedge i_clk);
    #1;
    i_we   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h", tag, actual, expected);
    end
  endtask

  task automatic rd(input logic [15:0] addr);
    applyStimulus(addr, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(addr, data, 1'b1);
  endtask

  initial begin
    i_rst  = 1'b1;
    i_addr = 16'h0000;
    i_data = 8'h00;
    i_we   = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_data", o_data, 8'h00);
    checkOutput("rst_irq", {7'b0, o_irq}, 8'h00);
    #4;
    i_rst = 1'b0;

    // Vectors
    rd(16'hFFFC); checkOutput("vec_fffc", o_data, 8'h00);
    rd(16'hFFFD); checkOutput("vec_fffd", o_data, 8'h02);
    rd(16'hFFFE); checkOutput("vec_fffe", o_data, 8'h00);
    rd(16'hFFFF); checkOutput("vec_ffff", o_data, 8'h03);
    wr(16'hFFFC, 8'h77);
    rd(16'hFFFC); checkOutput("vec_wr_ignored", o_data, 8'h00);

    // RAM and open bus
    wr(16'h0123, 8'h5A);
    rd(16'h0123); checkOutput("ram_rd", o_data, 8'h5A);
    rd(16'h0800); checkOutput("ram_above", o_data, 8'hFF);
    wr(16'h0123, 8'hA5); checkOutput("ram_read_first", o_data, 8'h5A);
    rd(16'h0123); checkOutput("ram_rd2", o_data, 8'hA5);
    wr(16'h07FF, 8'h3C);
    rd(16'h07FF); checkOutput("ram_top", o_data, 8'h3C);
    rd(16'h1234); checkOutput("open_bus", o_data, 8'hFF);
    rd(16'hD006); checkOutput("tmr_off6", o_data, 8'hFF);
    rd(16'hD007); checkOutput("tmr_off7", o_data, 8'hFF);

    // One-shot: RLD=3, CTRL=03 -> expiry 4 edges after the CTRL write
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    rd(16'hD001); checkOutput("rld_hi_rd", o_data, 8'h00);
    wr(16'hD002, 8'h03);
    rd(16'hD004); checkOutput("os_cnt3", o_data, 8'h03);
    rd(16'hD004); checkOutput("os_cnt2", o_data, 8'h02);
    rd(16'hD004); checkOutput("os_cnt1", o_data, 8'h01);
    checkOutput("os_irq_pre", {7'b0, o_irq}, 8'h00);
    rd(16'hD003); checkOutput("os_stat_pre", o_data, 8'h00);
    checkOutput("os_irq", {7'b0, o_irq}, 8'h01);
    rd(16'hD003); checkOutput("os_stat", o_data, 8'h01);
    rd(16'hD002); checkOutput("os_en_clr", o_data, 8'h02);
    rd(16'hD004); checkOutput("os_cnt0", o_data, 8'h00);
    checkOutput("os_irq_hold", {7'b0, o_irq}, 8'h01);
    wr(16'hD003, 8'h01);
    checkOutput("os_w1c_irq", {7'b0, o_irq}, 8'h00);

    // Auto-reload: RLD=1, CTRL=07 -> expiry every 2 cycles
    wr(16'hD000, 8'h01);
    wr(16'hD002, 8'h07);
    rd(16'hD004); checkOutput("au_cnt1", o_data, 8'h01);
    checkOutput("au_irq0", {7'b0, o_irq}, 8'h00);
    rd(16'hD004); checkOutput("au_cnt0", o_data, 8'h00);
    checkOutput("au_irq1", {7'b0, o_irq}, 8'h01);
    rd(16'hD004); checkOutput("au_reload", o_data, 8'h01);
    wr(16'hD003, 8'h01); checkOutput("au_w1c_old", o_data, 8'h01);
    checkOutput("au_tie_irq", {7'b0, o_irq}, 8'h01);
    rd(16'hD003); checkOutput("au_tie_stat", o_data, 8'h01);
    rd(16'hD004);
    wr(16'hD003, 8'h01);
    checkOutput("au_w1c_irq", {7'b0, o_irq}, 8'h00);

    // Freeze: stop, reload 0x20, run, stop with IRQEN kept
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    wr(16'hD000, 8'h20);
    wr(16'hD002, 8'h03);
    rd(16'hD004); checkOutput("fr_cnt20", o_data, 8'h20);
    rd(16'hD004); checkOutput("fr_cnt1f", o_data, 8'h1F);
    wr(16'hD002, 8'h02); checkOutput("fr_ctrl_old", o_data, 8'h03);
    rd(16'hD004); checkOutput("fr_frozen1", o_data, 8'h1E);
    rd(16'hD004); checkOutput("fr_frozen2", o_data, 8'h1E);
    wr(16'hD004, 8'hFF);
    rd(16'hD004); checkOutput("ro_ignored", o_data, 8'h1E);

    // Reload 0 one-shot: expires immediately after load
    wr(16'hD000, 8'h00);
    wr(16'hD002, 8'h03);
    rd(16'hD003); checkOutput("z_stat_pre", o_data, 8'h00);
    checkOutput("z_irq", {7'b0, o_irq}, 8'h01);
    wr(16'hD002, 8'h02);
    rd(16'hD003); checkOutput("stop_keeps_exp", o_data, 8'h01);
    checkOutput("stop_irq", {7'b0, o_irq}, 8'h01);
    wr(16'hD003, 8'h01); checkOutput("z_w1c_old", o_data, 8'h01);
    checkOutput("z_w1c_irq", {7'b0, o_irq}, 8'h00);
    rd(16'hD003); checkOutput("z_stat_clr", o_data, 8'h00);

    // Async reset mid-count with o_irq high
    wr(16'hD000, 8'h05);
    wr(16'hD002, 8'h07);
    for (int i = 0; i < 6; i++) rd(16'hD004);
    rd(16'hD002); checkOutput("mr_ctrl", o_data, 8'h07);
    checkOutput("mr_irq_pre", {7'b0, o_irq}, 8'h01);
    #1;
    i_rst = 1'b1;
    #1;
    checkOutput("mr_data", o_data, 8'h00);
    checkOutput("mr_irq", {7'b0, o_irq}, 8'h00);
    #1;
    i_rst = 1'b0;
    rd(16'hD002); checkOutput("mr_ctrl_clr", o_data, 8'h00);
    rd(16'hD003); checkOutput("mr_stat_clr", o_data, 8'h00);
    checkOutput("mr_irq_post", {7'b0, o_irq}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
